// File: rtl/beam_thresh_loader.sv
// beam_thresh_loader
// Upstream stage of the dual-beam DSP threshold comparators. Keeps a shadow
// table of per-beam thresholds written from the register side. On request it
// walks the table onto the shared thresh bus, one beam clock-enable at a
// time, then fires a single common update strobe so that every beam switches
// its active threshold on the same clock.
// Beam 2j drives DSP pair j ce[0]; beam 2j+1 drives DSP pair j ce[1].

module beam_thresh_loader #(
    parameter int unsigned              NBEAMS         = 48,
    parameter int unsigned              THRESH_BITS    = 18,
    parameter logic [THRESH_BITS-1:0]   DEFAULT_THRESH = 18'h3FFFF,
    parameter bit                       AUTOLOAD       = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        thresh_wr_i,
    input  logic [$clog2(NBEAMS)-1:0]   thresh_addr_i,
    input  logic [THRESH_BITS-1:0]      thresh_dat_i,
    output logic [THRESH_BITS-1:0]      thresh_rdat_o,
    input  logic                        load_i,
    output logic [THRESH_BITS-1:0]      thresh_o,
    output logic [NBEAMS-1:0]           thresh_ce_o,
    output logic                        update_o,
    output logic                        busy_o
);

    localparam int unsigned        AW       = $clog2(NBEAMS);
    localparam logic [AW:0]        NBEAMS_C = (AW+1)'(NBEAMS);
    localparam logic [AW-1:0]      LAST_IDX = AW'(NBEAMS - 1);
    localparam logic [AW-1:0]      IDX_ONE  = AW'(1);
    localparam logic [NBEAMS-1:0]  CE_ONE   = NBEAMS'(1);

    // IDLE: nothing on the bus. LOAD: ce/thresh for beam idx_r are being
    // presented. UPDATE: the common update strobe is being presented.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [THRESH_BITS-1:0]    shadow_r [NBEAMS];
    logic [AW-1:0]             idx_r;
    logic [AW-1:0]             idx_s;
    logic [AW-1:0]             nxt_idx_s;
    logic                      pending_r;
    logic                      pending_s;
    logic                      autoload_r;
    logic                      go_s;
    logic                      addr_ok_s;
    logic                      wr_en_s;
    logic [THRESH_BITS-1:0]    rd_val_s;
    logic [THRESH_BITS-1:0]    rdat_r;
    logic [THRESH_BITS-1:0]    thresh_r;
    logic [THRESH_BITS-1:0]    thresh_s;
    logic [NBEAMS-1:0]         ce_r;
    logic [NBEAMS-1:0]         ce_s;
    logic                      update_r;
    logic                      update_s;
    logic                      busy_r;
    logic                      busy_s;

    // Decide whether the register-side address names a real beam
    always_comb begin
        addr_ok_s = ({1'b0, thresh_addr_i} < NBEAMS_C);
        wr_en_s   = thresh_wr_i & addr_ok_s;
    end

    // Shadow table: every entry returns to the default on reset, one entry per write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NBEAMS; i++) begin
                shadow_r[i] <= DEFAULT_THRESH;
            end
        end else begin
            for (int i = 0; i < NBEAMS; i++) begin
                if (wr_en_s && (thresh_addr_i == AW'(i))) begin
                    shadow_r[i] <= thresh_dat_i;
                end else begin
                    shadow_r[i] <= shadow_r[i];
                end
            end
        end
    end

    // Readback value; a write on the same edge is forwarded so the table looks write-first
    always_comb begin
        rd_val_s = {THRESH_BITS{1'b0}};
        if (!addr_ok_s) begin
            rd_val_s = {THRESH_BITS{1'b0}};
        end else if (thresh_wr_i) begin
            rd_val_s = thresh_dat_i;
        end else begin
            rd_val_s = shadow_r[thresh_addr_i];
        end
    end

    // Registered readback port
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdat_r <= {THRESH_BITS{1'b0}};
        end else begin
            rdat_r <= rd_val_s;
        end
    end

    // One-shot load request generated by the first edge after reset release
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            autoload_r <= AUTOLOAD;
        end else begin
            autoload_r <= 1'b0;
        end
    end

    // Sequencer next state and next registered outputs
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        pending_s = pending_r;
        nxt_idx_s = {AW{1'b0}};
        go_s      = 1'b0;
        ce_s      = {NBEAMS{1'b0}};
        update_s  = 1'b0;
        busy_s    = 1'b0;
        thresh_s  = thresh_r;

        case (state_r)
            ST_IDLE: begin
                pending_s = 1'b0;
                if (load_i || pending_r || autoload_r) begin
                    go_s      = 1'b1;
                    nxt_idx_s = {AW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Requests arriving mid-walk collapse into a single follow-up sequence
                pending_s = pending_r | load_i;
                if (idx_r == LAST_IDX) begin
                    state_s  = ST_UPDATE;
                    update_s = 1'b1;
                    busy_s   = 1'b1;
                end else begin
                    go_s      = 1'b1;
                    nxt_idx_s = idx_r + IDX_ONE;
                end
            end
            ST_UPDATE: begin
                // A queued or coincident request restarts right after the strobe
                pending_s = 1'b0;
                if (load_i || pending_r) begin
                    go_s      = 1'b1;
                    nxt_idx_s = {AW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                pending_s = 1'b0;
            end
        endcase

        if (go_s) begin
            state_s = ST_LOAD;
            idx_s   = nxt_idx_s;
            ce_s    = CE_ONE << nxt_idx_s;
            busy_s  = 1'b1;
            // A write landing on this same edge must be part of the load
            if (wr_en_s && (thresh_addr_i == nxt_idx_s)) begin
                thresh_s = thresh_dat_i;
            end else begin
                thresh_s = shadow_r[nxt_idx_s];
            end
        end else begin
            idx_s = idx_r;
        end
    end

    // Sequencer state and registered bus outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            idx_r     <= {AW{1'b0}};
            pending_r <= 1'b0;
            thresh_r  <= {THRESH_BITS{1'b0}};
            ce_r      <= {NBEAMS{1'b0}};
            update_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            pending_r <= pending_s;
            thresh_r  <= thresh_s;
            ce_r      <= ce_s;
            update_r  <= update_s;
            busy_r    <= busy_s;
        end
    end

    assign thresh_rdat_o = rdat_r;
    assign thresh_o      = thresh_r;
    assign thresh_ce_o   = ce_r;
    assign update_o      = update_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Bench for beam_thresh_loader: a 4-beam instance driven against a
// cycle-level reference model through a scoreboard queue, plus a 6-beam
// autoload instance used for the power-up sequence and out-of-range addresses.

module tb_beam_thresh_loader;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // 4-beam instance, no autoload
    logic        rst4, wr4, ld4;
    logic [1:0]  addr4;
    logic [17:0] dat4, rdat4, thr4;
    logic [3:0]  ce4;
    logic        upd4, busy4;

    // 6-beam instance, autoload enabled
    logic        rst6, wr6, ld6;
    logic [2:0]  addr6;
    logic [17:0] dat6, rdat6, thr6;
    logic [5:0]  ce6;
    logic        upd6, busy6;

    beam_thresh_loader #(
        .NBEAMS(4), .THRESH_BITS(18), .DEFAULT_THRESH(18'h3FFFF), .AUTOLOAD(1'b0)
    ) u_dut4 (
        .clk_i(clk_i), .rst_i(rst4), .thresh_wr_i(wr4), .thresh_addr_i(addr4),
        .thresh_dat_i(dat4), .thresh_rdat_o(rdat4), .load_i(ld4), .thresh_o(thr4),
        .thresh_ce_o(ce4), .update_o(upd4), .busy_o(busy4)
    );

    beam_thresh_loader #(
        .NBEAMS(6), .THRESH_BITS(18), .DEFAULT_THRESH(18'h3FFFF), .AUTOLOAD(1'b1)
    ) u_dut6 (
        .clk_i(clk_i), .rst_i(rst6), .thresh_wr_i(wr6), .thresh_addr_i(addr6),
        .thresh_dat_i(dat6), .thresh_rdat_o(rdat6), .load_i(ld6), .thresh_o(thr6),
        .thresh_ce_o(ce6), .update_o(upd6), .busy_o(busy6)
    );

    int checks_cnt = 0;
    int errors_cnt = 0;

    typedef struct {
        logic [7:0]  ce;
        logic [17:0] thr;
        logic        upd;
        logic        busy;
        logic [17:0] rdat;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state for the 4-beam instance
    logic [17:0] m_shadow [4];
    int          m_pos;   // 0 idle, k+1 presenting beam k, 5 presenting update
    bit          m_pend;
    logic [17:0] m_thr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_shadow[i] = 18'h3FFFF;
        m_pos  = 0;
        m_pend = 1'b0;
        m_thr  = 18'h00000;
        exp_q.delete();
    endtask

    // Advance the model on a clock edge using the inputs the DUT sees, and queue the outcome
    task automatic model_step();
        exp_t e;
        if (wr4) m_shadow[addr4] = dat4;
        e.rdat = m_shadow[addr4];
        if (m_pos == 0) begin
            if (ld4 || m_pend) begin m_pos = 1; m_pend = 1'b0; end
        end else if (m_pos <= 4) begin
            if (ld4) m_pend = 1'b1;
            m_pos = m_pos + 1;
        end else begin
            if (ld4 || m_pend) m_pos = 1;
            else m_pos = 0;
            m_pend = 1'b0;
        end
        e.ce   = 8'h00;
        e.upd  = 1'b0;
        e.busy = (m_pos != 0);
        if (m_pos >= 1 && m_pos <= 4) begin
            e.ce  = 8'h01 << (m_pos - 1);
            m_thr = m_shadow[m_pos - 1];
        end else if (m_pos == 5) begin
            e.upd = 1'b1;
        end
        e.thr = m_thr;
        exp_q.push_back(e);
    endtask

    // One clock of the 4-beam instance: drive, clock, compare against the scoreboard
    task automatic step(input bit wr, input logic [1:0] a, input logic [17:0] d, input bit ld);
        exp_t e;
        wr4 = wr; addr4 = a; dat4 = d; ld4 = ld;
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("ce", {28'd0, ce4}, {24'd0, e.ce});
            check_val("thresh", {14'd0, thr4}, {14'd0, e.thr});
            check_val("update", {31'd0, upd4}, {31'd0, e.upd});
            check_val("busy", {31'd0, busy4}, {31'd0, e.busy});
            check_val("rdat", {14'd0, rdat4}, {14'd0, e.rdat});
        end
        wr4 = 1'b0; ld4 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e6;
        exp_t q6[$];

        rst4 = 1'b1; wr4 = 1'b0; ld4 = 1'b0; addr4 = 2'd0; dat4 = 18'h0;
        rst6 = 1'b1; wr6 = 1'b0; ld6 = 1'b0; addr6 = 3'd0; dat6 = 18'h0;
        model_reset();
        repeat (2) @(negedge clk_i);

        // Reset state
        check_val("rst_ce", {28'd0, ce4}, 32'd0);
        check_val("rst_thresh", {14'd0, thr4}, 32'd0);
        check_val("rst_update", {31'd0, upd4}, 32'd0);
        check_val("rst_busy", {31'd0, busy4}, 32'd0);
        check_val("rst_rdat", {14'd0, rdat4}, 32'd0);
        rst4 = 1'b0;

        // Default readback of every entry
        for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 18'h0, 1'b0);

        // Program the table, then one load
        step(1'b1, 2'd0, 18'h13880, 1'b0);
        step(1'b1, 2'd1, 18'h00100, 1'b0);
        step(1'b1, 2'd2, 18'h2AAAA, 1'b0);
        step(1'b1, 2'd3, 18'h3FFFE, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 18'h0, 1'b0);
        step(1'b0, 2'd0, 18'h0, 1'b1);
        repeat (6) step(1'b0, 2'd0, 18'h0, 1'b0);

        // Two requests while busy collapse into one back-to-back sequence
        step(1'b0, 2'd0, 18'h0, 1'b1);
        step(1'b0, 2'd0, 18'h0, 1'b1);
        step(1'b0, 2'd0, 18'h0, 1'b0);
        step(1'b0, 2'd0, 18'h0, 1'b1);
        repeat (12) step(1'b0, 2'd0, 18'h0, 1'b0);

        // Writes during a walk: beam 3 still ahead of the walk, beam 0 already behind
        step(1'b0, 2'd0, 18'h0, 1'b1);
        step(1'b0, 2'd0, 18'h0, 1'b0);
        step(1'b1, 2'd3, 18'h00055, 1'b0);
        step(1'b1, 2'd0, 18'h0ABCD, 1'b0);
        repeat (4) step(1'b0, 2'd0, 18'h0, 1'b0);
        step(1'b0, 2'd0, 18'h0, 1'b1);
        repeat (6) step(1'b0, 2'd0, 18'h0, 1'b0);

        // Write coinciding with the load edge is included
        step(1'b1, 2'd0, 18'h01111, 1'b1);
        repeat (6) step(1'b0, 2'd0, 18'h0, 1'b0);

        // Reset while beam 2 is on the bus
        step(1'b0, 2'd0, 18'h0, 1'b1);
        step(1'b0, 2'd0, 18'h0, 1'b0);
        step(1'b0, 2'd0, 18'h0, 1'b0);
        rst4 = 1'b1;
        #1;
        check_val("midrst_ce", {28'd0, ce4}, 32'd0);
        check_val("midrst_thresh", {14'd0, thr4}, 32'd0);
        check_val("midrst_update", {31'd0, upd4}, 32'd0);
        check_val("midrst_busy", {31'd0, busy4}, 32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        check_val("midrst_no_update", {31'd0, upd4}, 32'd0);
        @(negedge clk_i);
        rst4 = 1'b0;
        repeat (6) step(1'b0, 2'd0, 18'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 18'h0, 1'b0);

        // Autoload instance: quiet under reset, then one full default sequence
        check_val("al_rst_ce", {26'd0, ce6}, 32'd0);
        check_val("al_rst_busy", {31'd0, busy6}, 32'd0);
        check_val("al_rst_update", {31'd0, upd6}, 32'd0);
        check_val("al_rst_thresh", {14'd0, thr6}, 32'd0);
        for (int j = 0; j < 9; j++) begin
            e6.rdat = 18'h0;
            e6.thr  = 18'h3FFFF;
            e6.ce   = (j < 6) ? (8'h01 << j) : 8'h00;
            e6.upd  = (j == 6);
            e6.busy = (j <= 6);
            q6.push_back(e6);
        end
        rst6 = 1'b0;
        for (int j = 0; j < 9; j++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            e6 = q6.pop_front();
            check_val("al_ce", {26'd0, ce6}, {24'd0, e6.ce});
            check_val("al_thresh", {14'd0, thr6}, {14'd0, e6.thr});
            check_val("al_update", {31'd0, upd6}, {31'd0, e6.upd});
            check_val("al_busy", {31'd0, busy6}, {31'd0, e6.busy});
        end

        // Out-of-range addresses: write ignored, readback 0
        addr6 = 3'd6; wr6 = 1'b1; dat6 = 18'h12345;
        @(posedge clk_i);
        @(negedge clk_i);
        wr6 = 1'b0;
        check_val("oor_rd6", {14'd0, rdat6}, 32'd0);
        addr6 = 3'd7;
        @(posedge clk_i);
        @(negedge clk_i);
        check_val("oor_rd7", {14'd0, rdat6}, 32'd0);
        addr6 = 3'd2;
        @(posedge clk_i);
        @(negedge clk_i);
        check_val("oor_rd2", {14'd0, rdat6}, 32'h3FFFF);
        addr6 = 3'd5;
        @(posedge clk_i);
        @(negedge clk_i);
        check_val("oor_rd5", {14'd0, rdat6}, 32'h3FFFF);
        check_val("oor_busy", {31'd0, busy6}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
